mem_access_stage: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline, between the EX/MEM register and the MEM/WB register. It performs loads and stores to a word-organised data RAM with a configurable number of wait states. It holds the pipeline with a stall while an access is in flight. It produces the stage result `M_D`, which the MEM/WB register captures: load data sign- or zero-extended, or the ALU result for non-memory instructions.

---
 rtl/mips_pkg.sv | 11 +
 rtl/mem_access_stage_if.sv | 25 ++
 rtl/dm_ram.sv | 23 ++
 rtl/mem_access_stage.sv | 88 ++++++++
 tb/tb_mem_access_stage.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: access-size encodings and default
// memory latency.
package mips_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int LAT_DEF = 2;

endpackage

// File: rtl/mem_access_stage_if.sv
// EX/MEM -> MEM stage bundle: instruction fields in, stage result and
// stall/exception flags out.
interface mem_access_stage_if;
  logic [31:0] M_alu;
  logic [31:0] M_wdata;
  logic        M_MemRead;
  logic        M_MemWrite;
  logic [1:0]  M_size;
  logic        M_lu;
  logic        M_flush;
  logic [31:0] M_D;
  logic        mem_stall;
  logic        M_adel;
  logic        M_ades;

  modport master (
    output M_alu, M_wdata, M_MemRead, M_MemWrite, M_size, M_lu, M_flush,
    input  M_D, mem_stall, M_adel, M_ades
  );

  modport slave (
    input  M_alu, M_wdata, M_MemRead, M_MemWrite, M_size, M_lu, M_flush,
    output M_D, mem_stall, M_adel, M_ades
  );
endinterface

// File: rtl/dm_ram.sv
// Word-organised data RAM: one byte-wide array per lane, synchronous
// byte-enabled write, asynchronous read. Contents survive reset.
module dm_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk)
      if (we && be[l]) mem[addr] <= wdata[8*l +: 8];

    assign rdata[8*l +: 8] = mem[addr];
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: aligned byte/half/word loads and stores against dm_ram
// with LAT wait states, stalling the pipeline while an access is in flight.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LAT    = LAT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_stage_if.slave  m
);

  localparam int             CW    = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam logic [CW-1:0]  LAT_C = CW'(LAT);

  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    lane;
  logic          is_load, is_store, mis, op, done, we;
  logic [3:0]    be;
  logic [31:0]   wd, rdata, ld;
  logic [7:0]    b_sel;
  logic [15:0]   h_sel;

  assign lane     = m.M_alu[1:0];
  assign is_store = m.M_MemWrite;
  assign is_load  = m.M_MemRead & ~m.M_MemWrite;

  // Size 2'b11 is unused; it is treated like a word access.
  assign mis  = (m.M_size == SZ_BYTE) ? 1'b0 :
                (m.M_size == SZ_HALF) ? lane[0] : |lane;
  assign op   = (m.M_MemRead | m.M_MemWrite) & ~mis & ~m.M_flush;
  assign done = op & (cnt == LAT_C);
  assign we   = done & is_store & rst_n;

  // Counter returns to 0 on completion, flush or when no op is present.
  always_comb begin
    cnt_nxt = '0;
    if (op && cnt != LAT_C) cnt_nxt = cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;

  always_comb begin
    be = 4'hF;
    wd = m.M_wdata;
    case (m.M_size)
      SZ_BYTE: begin
        be = 4'b0001 << lane;
        wd = {4{m.M_wdata[7:0]}};
      end
      SZ_HALF: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{m.M_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  dm_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .be    (be),
    .addr  (m.M_alu[ADDR_W+1:2]),
    .wdata (wd),
    .rdata (rdata)
  );

  assign b_sel = rdata[{lane, 3'b000} +: 8];
  assign h_sel = lane[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ld = rdata;
    case (m.M_size)
      SZ_BYTE: ld = m.M_lu ? {24'b0, b_sel} : {{24{b_sel[7]}}, b_sel};
      SZ_HALF: ld = m.M_lu ? {16'b0, h_sel} : {{16{h_sel[15]}}, h_sel};
      default: ;
    endcase
  end

  assign m.M_D       = !rst_n ? 32'b0 : (is_load & ~mis) ? ld : m.M_alu;
  assign m.mem_stall = rst_n & op & (cnt != LAT_C);
  assign m.M_adel    = rst_n & mis & is_load;
  assign m.M_ades    = rst_n & mis & is_store;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboarded bench for mem_access_stage: one LAT=0 and one LAT=2 instance
// sharing stimulus, checked against a byte-level memory model.
module tb_mem_access_stage;
  import mips_pkg::*;

  localparam int AW = 10;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] alu = '0, wdata = '0;
  logic        rd = 0, wr = 0, lu = 0, flush = 0;
  logic [1:0]  sz = SZ_WORD;
  int          cur = 0;
  bit          act = 0;

  mem_access_stage_if if0 ();
  mem_access_stage_if if2 ();

  assign if0.M_alu = alu;  assign if2.M_alu = alu;
  assign if0.M_wdata = wdata;  assign if2.M_wdata = wdata;
  assign if0.M_size = sz;  assign if2.M_size = sz;
  assign if0.M_lu = lu;  assign if2.M_lu = lu;
  assign if0.M_MemRead  = rd & (cur == 0);  assign if2.M_MemRead  = rd & (cur == 1);
  assign if0.M_MemWrite = wr & (cur == 0);  assign if2.M_MemWrite = wr & (cur == 1);
  assign if0.M_flush    = flush & (cur == 0); assign if2.M_flush  = flush & (cur == 1);

  mem_access_stage #(.ADDR_W(AW), .LAT(0)) dut0 (.clk(clk), .rst_n(rst_n), .m(if0));
  mem_access_stage #(.ADDR_W(AW), .LAT(2)) dut2 (.clk(clk), .rst_n(rst_n), .m(if2));

  logic [31:0] o_d;
  logic        o_stall, o_adel, o_ades;
  assign o_d     = (cur == 0) ? if0.M_D       : if2.M_D;
  assign o_stall = (cur == 0) ? if0.mem_stall : if2.mem_stall;
  assign o_adel  = (cur == 0) ? if0.M_adel    : if2.M_adel;
  assign o_ades  = (cur == 0) ? if0.M_ades    : if2.M_ades;

  typedef struct {
    logic [31:0] d;
    logic        adel;
    logic        ades;
    int          stalls;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, errors = 0;
  logic [31:0] mdl [2][1024];

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Reference: byte-addressed little-endian memory, 4 KiB window wraps.
  task automatic issue(int c, bit r, bit w, logic [1:0] s, bit u,
                       logic [31:0] a, logic [31:0] wd);
    exp_t        e;
    int          ba, wi, bl, nb, n;
    bit          misal, ld;
    longint      v;
    logic [31:0] tmp;
    ba = int'(a[11:0]);
    wi = ba / 4;
    bl = ba % 4;
    nb = (s == SZ_BYTE) ? 1 : (s == SZ_HALF) ? 2 : 4;
    misal = (ba % nb) != 0;
    ld = r && !w;
    e.d      = a;
    e.adel   = misal && ld;
    e.ades   = misal && w;
    e.stalls = ((r || w) && !misal) ? ((c == 0) ? 0 : 2) : 0;
    if (ld && !misal) begin
      v = longint'(mdl[c][wi] >> (8 * bl)) & ((longint'(1) << (8 * nb)) - 1);
      if (!u && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
      e.d = v[31:0];
    end
    if (w && !misal) begin
      tmp = mdl[c][wi];
      for (int k = 0; k < nb; k++) tmp[8 * (bl + k) +: 8] = wd[8 * k +: 8];
      mdl[c][wi] = tmp;
    end
    q.push_back(e);
    @(posedge clk); #1;
    cur = c; rd = r; wr = w; sz = s; lu = u; alu = a; wdata = wd; flush = 0; act = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (o_stall && n < 20);
    if (n >= 20) chk("stall_timeout", 32'(n), 32'd3);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    rd = 0; wr = 0; flush = 0; act = 0;
  endtask

  int scnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (act && rst_n) begin
      if (o_stall) scnt++;
      else begin
        if (q.size() == 0) chk("unexpected_output", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("M_D", o_d, e.d);
          chk("M_adel", 32'(o_adel), 32'(e.adel));
          chk("M_ades", 32'(o_ades), 32'(e.ades));
          chk("stall_cycles", 32'(scnt), 32'(e.stalls));
        end
        scnt = 0;
      end
    end
  end

  task automatic aborted_sw(bit use_rst);
    @(posedge clk); #1;
    cur = 1; rd = 0; wr = 1; sz = SZ_WORD; alu = 32'h20; wdata = 32'hDEADBEEF;
    @(negedge clk); chk("abort_c0_stall", 32'(o_stall), 32'd1);
    @(posedge clk); #1;
    if (use_rst) begin
      rst_n = 0;
      @(negedge clk);
      chk("rst_D2", if2.M_D, 32'h0);      chk("rst_D0", if0.M_D, 32'h0);
      chk("rst_stall2", 32'(if2.mem_stall), 32'd0);
      chk("rst_ades2", 32'(if2.M_ades), 32'd0);
      chk("rst_cnt2", 32'(dut2.cnt), 32'd0);
      @(posedge clk); #1;
      wr = 0; rst_n = 1;
    end else begin
      flush = 1;
      @(negedge clk); chk("flush_c1_stall", 32'(o_stall), 32'd0);
      @(posedge clk); #1;
      @(negedge clk); chk("flush_c2_stall", 32'(o_stall), 32'd0);
      @(posedge clk); #1;
      wr = 0; flush = 0;
    end
  endtask

  initial begin
    logic [31:0] ra;
    int          rs;
    @(negedge clk);
    chk("reset_D", if2.M_D, 32'h0);
    chk("reset_stall", 32'(if2.mem_stall), 32'd0);
    @(posedge clk); #1 rst_n = 1;

    for (int c = 0; c < 2; c++)
      for (int w = 0; w < 64; w++) issue(c, 0, 1, SZ_WORD, 0, 32'(w * 4), $urandom);

    issue(0, 0, 1, SZ_WORD, 0, 32'h10, 32'h12345678);
    issue(0, 1, 0, SZ_BYTE, 0, 32'h11, 0);
    issue(0, 1, 0, SZ_HALF, 0, 32'h12, 0);
    issue(0, 1, 0, SZ_WORD, 0, 32'h10, 0);
    issue(0, 0, 1, SZ_BYTE, 0, 32'h13, 32'hFFFFFF80);
    issue(0, 1, 0, SZ_WORD, 0, 32'h10, 0);
    issue(0, 1, 0, SZ_BYTE, 0, 32'h13, 0);
    issue(0, 1, 0, SZ_BYTE, 1, 32'h13, 0);
    issue(0, 1, 0, SZ_HALF, 1, 32'h12, 0);

    issue(1, 1, 0, SZ_WORD, 0, 32'h40, 0);
    issue(1, 1, 0, SZ_WORD, 0, 32'h44, 0);
    issue(1, 1, 0, SZ_WORD, 0, 32'h02, 0);
    issue(1, 0, 1, SZ_HALF, 0, 32'h05, 32'h0000BEEF);
    issue(1, 1, 0, SZ_WORD, 0, 32'h04, 0);
    issue(1, 1, 1, SZ_WORD, 0, 32'h08, 32'h0BADF00D);
    issue(1, 1, 0, SZ_WORD, 0, 32'h08, 0);
    idle();

    aborted_sw(0);
    issue(1, 1, 0, SZ_WORD, 0, 32'h20, 0);
    idle();
    aborted_sw(1);
    issue(1, 1, 0, SZ_WORD, 0, 32'h20, 0);
    issue(1, 0, 0, SZ_WORD, 0, 32'hCAFEF00D, 0);

    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      ra[11:8] = 4'h0;
      rs = $urandom_range(0, 2);
      issue($urandom_range(0, 1), 1'($urandom), 1'($urandom), 2'(rs), 1'($urandom),
            ra, $urandom);
    end
    idle();
    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
